// File: rtl/lsu_pkg.sv
// Load/store unit shared types: FSM state encoding and default widths.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional build macro consumed by the top: LSU_ALIGN_CHECK_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    localparam int LSU_ADDR_W = 16;
    localparam int LSU_DATA_W = 16;
    localparam int LSU_RD_W   = 3;

endpackage

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit driving a combinational-read data memory.
// Latency: accept at edge N, memory strobe in cycle N+1, response valid from edge N+2 (N+1 on misalign error).
// Backpressure: req_ready only in IDLE; response held stable until resp_ready. Macro: LSU_ALIGN_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W,
    parameter int RD_W   = LSU_RD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic [ADDR_W-1:0] mem_acess_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_is_store,
    output logic [RD_W-1:0]   resp_rd,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic              r_is_store;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [RD_W-1:0]   r_rd;
    logic [DATA_W-1:0] r_rdata;
    logic              w_accept;
    logic              w_misaligned;

    assign w_accept = req_valid && (r_state == IDLE);

`ifdef LSU_ALIGN_CHECK_EN
    logic r_err;

    assign w_misaligned = req_addr[0];
    assign resp_err     = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_misaligned;
        end
    end
`else
    assign w_misaligned = 1'b0;
    assign resp_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_misaligned ? RESP : ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        mem_write_en   = 1'b0;
        mem_read       = 1'b0;
        mem_write_data = '0;
        case (r_state)
            IDLE:    req_ready = 1'b1;
            ACCESS: begin
                mem_write_en   = r_is_store;
                mem_read       = !r_is_store;
                mem_write_data = r_is_store ? r_wdata : '0;
            end
            RESP:    resp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    // Load data is cleared on accept so stores and rejected requests report zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_rdata    <= '0;
        end else if (w_accept) begin
            r_is_store <= req_is_store;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rd       <= req_rd;
            r_rdata    <= '0;
        end else if (r_state == ACCESS && !r_is_store) begin
            r_rdata    <= mem_read_data;
        end
    end

    assign mem_acess_addr = r_addr;
    assign resp_is_store  = r_is_store;
    assign resp_rd        = r_rd;
    assign resp_rdata     = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model behind it.
// Expectations follow LSU_ALIGN_CHECK_EN when the same macro is defined for the bench.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [2:0]  req_rd;
    logic [15:0] mem_acess_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [15:0] mem_read_data;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_is_store;
    logic [2:0]  resp_rd;
    logic [15:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_wr = 0;
    int n_rd = 0;

    logic [15:0] mem [0:255];
    logic        mem_init_done = 1'b0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .mem_acess_addr (mem_acess_addr),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_is_store  (resp_is_store),
        .resp_rd        (resp_rd),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err)
    );

    // Memory contents start as 0xA500|index and survive later resets.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA500 | 16'(i);
            mem_init_done <= 1'b1;
        end else if (mem_write_en) begin
            mem[mem_acess_addr[7:0]] <= mem_write_data;
        end
    end

    assign mem_read_data = mem[mem_acess_addr[7:0]];

    always @(posedge clk) begin
        if (mem_write_en) n_wr <= n_wr + 1;
        if (mem_read)     n_rd <= n_rd + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Presents one request at the current falling edge; returns at the next falling edge (ACCESS cycle).
    task automatic send(input logic st, input logic [15:0] a, input logic [15:0] wd, input logic [2:0] rd);
        req_valid    = 1'b1;
        req_is_store = st;
        req_addr     = a;
        req_wdata    = wd;
        req_rd       = rd;
        @(negedge clk);
        req_valid    = 1'b0;
    endtask

    int w0, r0, idx, ridx, last;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0;
        req_wdata = '0; req_rd = '0; resp_ready = 1'b0;
        #2;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_is_store", resp_is_store, 0);
        chk("rst_resp_rd", resp_rd, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_addr", mem_acess_addr, 0);
        chk("rst_mem_wdata", mem_write_data, 0);
        chk("rst_mem_we", mem_write_en, 0);
        chk("rst_mem_rd", mem_read, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Store 0xBEEF to 0x0010
        chk("st_ready_idle", req_ready, 1);
        w0 = n_wr;
        send(1'b1, 16'h0010, 16'hBEEF, 3'd2);
        chk("st_we", mem_write_en, 1);
        chk("st_addr", mem_acess_addr, 16'h0010);
        chk("st_wdata", mem_write_data, 16'hBEEF);
        chk("st_no_read", mem_read, 0);
        chk("st_access_valid", resp_valid, 0);
        chk("st_access_ready", req_ready, 0);
        @(negedge clk);
        chk("st_we_off", mem_write_en, 0);
        chk("st_wdata_off", mem_write_data, 0);
        chk("st_addr_hold", mem_acess_addr, 16'h0010);
        chk("st_resp_valid", resp_valid, 1);
        chk("st_resp_is_store", resp_is_store, 1);
        chk("st_resp_err", resp_err, 0);
        chk("st_resp_rd", resp_rd, 2);
        chk("st_resp_rdata", resp_rdata, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("st_done_valid", resp_valid, 0);
        chk("st_done_ready", req_ready, 1);
        chk("st_we_count", n_wr - w0, 1);
        chk("st_mem", mem[16], 16'hBEEF);

        // Load it back
        send(1'b0, 16'h0010, 16'h0000, 3'd2);
        chk("ld_read", mem_read, 1);
        chk("ld_no_we", mem_write_en, 0);
        chk("ld_addr", mem_acess_addr, 16'h0010);
        @(negedge clk);
        chk("ld_resp_valid", resp_valid, 1);
        chk("ld_resp_rdata", resp_rdata, 16'hBEEF);
        chk("ld_resp_rd", resp_rd, 2);
        chk("ld_resp_is_store", resp_is_store, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // Load stalled by resp_ready=0 while a competing request is presented
        w0 = n_wr;
        send(1'b0, 16'h0020, 16'h0000, 3'd5);
        r0 = n_rd;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_addr = 16'h0050;
        req_wdata = 16'h1111; req_rd = 3'd7;
        for (int c = 0; c < 5; c++) begin
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, 16'hA520);
            chk("hold_rd", resp_rd, 5);
            chk("hold_is_store", resp_is_store, 0);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_no_read", mem_read, 0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("hold_read_count", n_rd - r0, 1);
        chk("hold_write_count", n_wr - w0, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("hold_released", resp_valid, 0);

        // Odd-address store
        w0 = n_wr;
        send(1'b1, 16'h0011, 16'h1234, 3'd3);
`ifdef LSU_ALIGN_CHECK_EN
        chk("mis_no_we", mem_write_en, 0);
        chk("mis_resp_valid", resp_valid, 1);
        chk("mis_resp_err", resp_err, 1);
        chk("mis_resp_rdata", resp_rdata, 0);
        chk("mis_resp_is_store", resp_is_store, 1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("mis_we_count", n_wr - w0, 0);
        chk("mis_mem", mem[17], 16'hA511);
`else
        chk("odd_we", mem_write_en, 1);
        chk("odd_addr", mem_acess_addr, 16'h0011);
        chk("odd_wdata", mem_write_data, 16'h1234);
        @(negedge clk);
        chk("odd_resp_valid", resp_valid, 1);
        chk("odd_resp_err", resp_err, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("odd_mem", mem[17], 16'h1234);
`endif

        // Reset in the middle of a store's ACCESS cycle
        send(1'b1, 16'h0030, 16'h5555, 3'd1);
        chk("rst_mid_we_before", mem_write_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_we", mem_write_en, 0);
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_addr", mem_acess_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_resp", resp_valid, 0);
        chk("rst_mid_mem", mem[48], 16'hA530);
        send(1'b1, 16'h0040, 16'h7777, 3'd4);
        chk("post_rst_we", mem_write_en, 1);
        chk("post_rst_wdata", mem_write_data, 16'h7777);
        @(negedge clk);
        chk("post_rst_valid", resp_valid, 1);
        chk("post_rst_rd", resp_rd, 4);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_rst_mem", mem[64], 16'h7777);

        // Eight back-to-back loads with valid/ready held high
        r0 = n_rd; idx = 0; ridx = 0; last = -1;
        req_valid = 1'b1; req_is_store = 1'b0; req_wdata = '0;
        req_addr = 16'h0080; req_rd = 3'd0; resp_ready = 1'b1;
        for (int c = 0; c < 60 && ridx < 8; c++) begin
            if (resp_valid) begin
                chk("b2b_rd", resp_rd, ridx);
                chk("b2b_rdata", resp_rdata, 16'hA580 + 16'(2 * ridx));
                ridx++;
            end
            if (req_valid && req_ready) begin
                if (last >= 0) chk("b2b_spacing", c - last, 3);
                last = c;
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx >= 8) begin
                req_valid = 1'b0;
            end else begin
                req_addr = 16'h0080 + 16'(2 * idx);
                req_rd   = 3'(idx);
            end
            @(negedge clk);
        end
        resp_ready = 1'b0;
        chk("b2b_accepts", idx, 8);
        chk("b2b_responses", ridx, 8);
        chk("b2b_reads", n_rd - r0, 8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
